div_sequencer: RTL and testbench
================================

Name: div_sequencer

Overview:
Multi-cycle controller and datapath for unsigned DIV/MOD in the execute stage. It replaces the single-cycle divide/modulo path with an iterative restoring divider that produces one quotient bit per cycle. While an operation is in flight it stalls the pipeline, and it releases the stall in the cycle the result is valid. It also accepts a flush from the branch unit to abandon an operation in flight.

Parameters:
WIDTH, 32, operand/result width in bits
CNT_W, 6, iteration counter width; must satisfy 2^CNT_W > WIDTH

Ports:
clk  input  1  system clock, all state updates on rising edge
rst  input  1  reset, synchronous, active-high
start  input  1  issue request for a DIV/MOD instruction in execute
isDiv  input  1  operation is divide (quotient result)
isMod  input  1  operation is modulo (remainder result)
flush  input  1  cancel the operation in flight (branch taken)
a  input  WIDTH  dividend (op1)
b  input  WIDTH  divisor (op2)
stall  output  1  hold the upstream pipeline
done  output  1  result valid, one-cycle pulse
result  output  WIDTH  quotient or remainder
div_by_zero  output  1  divisor was zero, valid with done

Behaviour:
- Clock/reset: one clock, clk. Reset rst is synchronous and active-high.
- Reset values: state=IDLE, count=0, quot=0, rem=0, divisor=0, op_div=0, done=0, result=0, div_by_zero=0. stall=0 after reset.
- Effective start: go = start & (isDiv | isMod) & (state==IDLE) & ~flush.
- Op select: if isDiv and isMod are both high, isDiv wins. The op is latched into op_div when go is accepted.
- States: IDLE, CALC, DONE.
- IDLE:
  - On go with b!=0: latch quot=a, rem=0, divisor=b, count=0; go to CALC.
  - On go with b==0: latch div_by_zero=1; result = all ones if op_div, else a; go to DONE.
- CALC, each cycle (one restoring step):
  - t = {rem[WIDTH-2:0], quot[WIDTH-1]} - divisor, computed at WIDTH+1 bits.
  - If t is non-negative: rem = t[WIDTH-1:0] and shift 1 into quot LSB.
  - Otherwise: rem = the shifted value and shift 0 into quot LSB.
  - count increments each step.
  - After the WIDTH-th step (count==WIDTH-1): result = quot_next if op_div, else rem_next; div_by_zero=0; go to DONE.
- DONE: done=1 for exactly this cycle; always go to IDLE next.
- done is registered; it is high only in DONE. result and div_by_zero hold their values until the next completion or reset.
- stall is combinational: stall = (state==IDLE & go) | (state==CALC).
  - stall is low in DONE, so the pipeline advances and captures result in that cycle.
- Latency, counting the go cycle as cycle 0:
  - Normal: done in cycle WIDTH+1 (cycle 33 for WIDTH=32).
  - Divide by zero: done in cycle 1.
  - Stall is high in cycles 0..WIDTH, or in cycle 0 only for divide by zero.
- start while in CALC or DONE: ignored; no queuing.
- flush:
  - In CALC or DONE: next state IDLE, done suppressed (forced 0 that cycle), result unchanged.
  - Same cycle as start in IDLE: start is ignored.
- Reset mid-operation: immediate return to IDLE with all reset values; no done.
- Arithmetic: unsigned only. Remainder < divisor always; quotient*divisor + remainder == a.

Test Plan:
- a=100, b=7, isDiv, start 1 cycle -> stall high cycles 0..32; done pulse cycle 33; result=14, div_by_zero=0; stall low at done.
- a=100, b=7, isMod -> done cycle 33, result=2.
- a=0xFFFFFFFF, b=1, isDiv -> result=0xFFFFFFFF; same a with b=0xFFFFFFFF, isMod -> result=0.
- b=0, a=0x1234, isDiv -> done cycle 1, result=0xFFFFFFFF, div_by_zero=1; repeat with isMod -> result=0x1234.
- Start 50/5 DIV, assert flush in cycle 10 -> stall drops cycle 11, no done; then start 9/4 isMod -> result=1 at cycle 33 of the new op.
- Second start pulses in cycles 5 and 20 of an op in flight -> ignored, single done, correct result; isDiv&isMod both high with 17/5 -> result=3; rst in cycle 15 -> IDLE, done=0, result=0.

Source files
------------

// File: rtl/div_sequencer.sv
// rtl/div_sequencer.sv - iterative restoring unsigned DIV/MOD sequencer with pipeline stall and flush
module div_sequencer #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 6
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             isDiv,
  input  logic             isMod,
  input  logic             flush,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             stall,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             div_by_zero
);

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   count_q, count_d;
  logic [WIDTH-1:0]   quot_q, quot_d;
  logic [WIDTH-1:0]   rem_q, rem_d;
  logic [WIDTH-1:0]   divisor_q, divisor_d;
  logic               op_div_q, op_div_d;
  logic               done_q, done_d;
  logic [WIDTH-1:0]   result_q, result_d;
  logic               dbz_q, dbz_d;

  logic               go;
  logic [WIDTH-1:0]   shifted;
  logic [WIDTH:0]     diff;
  logic [WIDTH-1:0]   rem_step;
  logic [WIDTH-1:0]   quot_step;

  assign go = start & (isDiv | isMod) & (state_q == IDLE) & ~flush;

  // rem is always below 2^(WIDTH-1) before a shift, so dropping its MSB loses nothing
  always_comb begin
    shifted = {rem_q[WIDTH-2:0], quot_q[WIDTH-1]};
    diff    = {1'b0, shifted} - {1'b0, divisor_q};
    if (!diff[WIDTH]) begin
      rem_step  = diff[WIDTH-1:0];
      quot_step = {quot_q[WIDTH-2:0], 1'b1};
    end else begin
      rem_step  = shifted;
      quot_step = {quot_q[WIDTH-2:0], 1'b0};
    end
  end

  always_comb begin
    state_d   = state_q;
    count_d   = count_q;
    quot_d    = quot_q;
    rem_d     = rem_q;
    divisor_d = divisor_q;
    op_div_d  = op_div_q;
    done_d    = 1'b0;
    result_d  = result_q;
    dbz_d     = dbz_q;
    case (state_q)
      IDLE: begin
        if (go) begin
          op_div_d = isDiv;
          if (b != '0) begin
            quot_d    = a;
            rem_d     = '0;
            divisor_d = b;
            count_d   = '0;
            state_d   = CALC;
          end else begin
            dbz_d    = 1'b1;
            result_d = isDiv ? {WIDTH{1'b1}} : a;
            done_d   = 1'b1;
            state_d  = DONE;
          end
        end
      end
      CALC: begin
        if (flush) begin
          state_d = IDLE;
        end else begin
          quot_d  = quot_step;
          rem_d   = rem_step;
          count_d = count_q + CNT_W'(1);
          if (count_q == CNT_W'(WIDTH - 1)) begin
            result_d = op_div_q ? quot_step : rem_step;
            dbz_d    = 1'b0;
            done_d   = 1'b1;
            state_d  = DONE;
          end
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      count_q   <= '0;
      quot_q    <= '0;
      rem_q     <= '0;
      divisor_q <= '0;
      op_div_q  <= 1'b0;
      done_q    <= 1'b0;
      result_q  <= '0;
      dbz_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      count_q   <= count_d;
      quot_q    <= quot_d;
      rem_q     <= rem_d;
      divisor_q <= divisor_d;
      op_div_q  <= op_div_d;
      done_q    <= done_d;
      result_q  <= result_d;
      dbz_q     <= dbz_d;
    end
  end

  // a flush arriving in DONE cancels the pulse the pipeline would otherwise capture
  assign done        = done_q & ~flush;
  assign stall       = ((state_q == IDLE) & go) | (state_q == CALC);
  assign result      = result_q;
  assign div_by_zero = dbz_q;

endmodule

// File: tb/tb_div_sequencer.sv
// tb/tb_div_sequencer.sv - scoreboard bench for div_sequencer
module tb_div_sequencer;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic        isDiv;
  logic        isMod;
  logic        flush;
  logic [31:0] a;
  logic [31:0] b;
  logic        stall;
  logic        done;
  logic [31:0] result;
  logic        div_by_zero;

  int total = 0;
  int bad   = 0;

  logic [32:0] sb_q[$];

  div_sequencer #(.WIDTH(32), .CNT_W(6)) dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .isDiv       (isDiv),
    .isMod       (isMod),
    .flush       (flush),
    .a           (a),
    .b           (b),
    .stall       (stall),
    .done        (done),
    .result      (result),
    .div_by_zero (div_by_zero)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [32:0] obs, input logic [32:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [32:0] model(input logic [31:0] av, input logic [31:0] bv,
                                        input logic dv);
    if (bv == 32'd0) return {1'b1, (dv ? 32'hFFFF_FFFF : av)};
    return {1'b0, (dv ? av / bv : av % bv)};
  endfunction

  // Issues one op in cycle 0 and watches 46 cycles; control events are given as cycle numbers (-1 = none).
  task automatic run_op(input string tag, input logic [31:0] av, input logic [31:0] bv,
                        input logic dv, input logic mv, input int flush_at, input int rst_at,
                        input int re1, input int re2, input bit expect_done,
                        input int exp_lat, input int exp_stall);
    int done_cnt;
    int done_cyc;
    int stall_cnt;
    logic [32:0] exp_v;
    done_cnt  = 0;
    done_cyc  = -1;
    stall_cnt = 0;
    if (expect_done) sb_q.push_back(model(av, bv, dv));
    @(posedge clk);
    #1;
    for (int cyc = 0; cyc < 46; cyc++) begin
      start = (cyc == 0) || (cyc == re1) || (cyc == re2);
      isDiv = dv;
      isMod = mv;
      a     = (cyc == 0) ? av : 32'hDEAD_BEEF;
      b     = (cyc == 0) ? bv : 32'd3;
      flush = (cyc == flush_at);
      rst   = (cyc == rst_at);
      @(negedge clk);
      if (stall) stall_cnt++;
      if (done) begin
        done_cnt++;
        done_cyc = cyc;
        if (sb_q.size() == 0) begin
          check({tag, "_unexpected_done"}, 33'd1, 33'd0);
        end else begin
          exp_v = sb_q.pop_front();
          check({tag, "_result"}, {div_by_zero, result}, exp_v);
        end
      end
      @(posedge clk);
      #1;
    end
    start = 1'b0;
    flush = 1'b0;
    rst   = 1'b0;
    check({tag, "_done_count"}, 33'(done_cnt), expect_done ? 33'd1 : 33'd0);
    if (expect_done) check({tag, "_latency"}, 33'(done_cyc), 33'(exp_lat));
    check({tag, "_stall_cycles"}, 33'(stall_cnt), 33'(exp_stall));
  endtask

  initial begin
    rst   = 1'b1;
    start = 1'b0;
    isDiv = 1'b0;
    isMod = 1'b0;
    flush = 1'b0;
    a     = '0;
    b     = '0;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    check("reset_stall", {32'd0, stall}, 33'd0);
    check("reset_done", {32'd0, done}, 33'd0);
    check("reset_result", {div_by_zero, result}, 33'd0);

    run_op("div_100_7", 32'd100, 32'd7, 1'b1, 1'b0, -1, -1, -1, -1, 1'b1, 33, 33);
    check("div_100_7_literal", {1'b0, result}, 33'd14);
    run_op("mod_100_7", 32'd100, 32'd7, 1'b0, 1'b1, -1, -1, -1, -1, 1'b1, 33, 33);
    check("mod_100_7_literal", {1'b0, result}, 33'd2);
    run_op("div_max_1", 32'hFFFF_FFFF, 32'd1, 1'b1, 1'b0, -1, -1, -1, -1, 1'b1, 33, 33);
    run_op("mod_max_max", 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 1'b1, -1, -1, -1, -1, 1'b1, 33, 33);
    run_op("div_by_zero", 32'h1234, 32'd0, 1'b1, 1'b0, -1, -1, -1, -1, 1'b1, 1, 1);
    check("dbz_div_literal", {div_by_zero, result}, {1'b1, 32'hFFFF_FFFF});
    run_op("mod_by_zero", 32'h1234, 32'd0, 1'b0, 1'b1, -1, -1, -1, -1, 1'b1, 1, 1);
    check("dbz_mod_literal", {div_by_zero, result}, {1'b1, 32'h1234});
    run_op("flush_50_5", 32'd50, 32'd5, 1'b1, 1'b0, 10, -1, -1, -1, 1'b0, 0, 11);
    check("flush_keeps_result", {div_by_zero, result}, {1'b1, 32'h1234});
    run_op("mod_9_4", 32'd9, 32'd4, 1'b0, 1'b1, -1, -1, -1, -1, 1'b1, 33, 33);
    check("mod_9_4_literal", {1'b0, result}, 33'd1);
    run_op("both_17_5_restart", 32'd17, 32'd5, 1'b1, 1'b1, -1, -1, 5, 20, 1'b1, 33, 33);
    check("both_17_5_literal", {1'b0, result}, 33'd3);
    run_op("rst_mid_op", 32'd17, 32'd5, 1'b1, 1'b0, -1, 15, -1, -1, 1'b0, 0, 16);
    check("rst_mid_result", {div_by_zero, result}, 33'd0);
    @(negedge clk);
    check("rst_mid_stall", {32'd0, stall}, 33'd0);

    for (int i = 0; i < 4; i++) begin
      logic [31:0] ra;
      logic [31:0] rb;
      logic        rd;
      ra = $urandom();
      rb = $urandom() >> $urandom_range(31, 0);
      rd = 1'(i & 1);
      if (rb == 32'd0) rb = 32'd13;
      run_op("random_op", ra, rb, rd, ~rd, -1, -1, -1, -1, 1'b1, 33, 33);
    end

    check("scoreboard_empty", 33'(sb_q.size()), 33'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
